// File: rtl/qed_pkg.sv
// Shared types, default geometry and elaboration helpers for the QED consistency checker.
package qed_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT,
        ST_FAIL
    } state_e;

    // Geometry of the default build (32 registers, one lane).
    localparam int P      = 16;
    localparam int B      = 16;
    localparam int IDX_W  = 4;
    localparam int BEAT_W = 5;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit params_ok(input int num_regs, input int lanes);
        return (num_regs >= 2) && (num_regs % 2 == 0) && (lanes > 0) &&
               ((num_regs / 2) % lanes == 0);
    endfunction

endpackage

// File: rtl/qed_pair_compare.sv
// Compares LANES original/duplicate register pairs; reports the lowest mismatching pair index.
module qed_pair_compare
    import qed_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LANES   = 1,
    parameter int IDX_W   = 4,
    parameter int SKIP_R0 = 1
) (
    input  logic [LANES*XLEN-1:0] orig_i,
    input  logic [LANES*XLEN-1:0] dup_i,
    input  logic [LANES-1:0]      mask_i,
    input  logic [IDX_W-1:0]      base_i,
    output logic                  any_mismatch_o,
    output logic [IDX_W-1:0]      mis_idx_o
);

    logic [IDX_W-1:0] pair_idx;
    logic             excluded;

    // Walk lanes high to low so the lowest mismatching lane is written last.
    always_comb begin
        any_mismatch_o = 1'b0;
        mis_idx_o      = '0;
        pair_idx       = '0;
        excluded       = 1'b0;
        for (int l = LANES - 1; l >= 0; l--) begin
            pair_idx = base_i + IDX_W'(l);
            excluded = mask_i[l] || ((SKIP_R0 != 0) && (pair_idx == '0));
            if (!excluded && (orig_i[l*XLEN +: XLEN] != dup_i[l*XLEN +: XLEN])) begin
                any_mismatch_o = 1'b1;
                mis_idx_o      = pair_idx;
            end
        end
    end

endmodule

// File: rtl/qed_consistency_checker.sv
// QED consistency checker: commit counters, register-file snapshot and pairwise scan FSM.
// state  | meaning
// IDLE   | waiting for a check request with balanced commit counts
// SCAN   | comparing LANES snapshot pairs per cycle
// REPORT | one-cycle done/pass pulse, bump completed-check count
// FAIL   | sticky mismatch, left only by rst or clear_i
module qed_consistency_checker
    import qed_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int LANES    = 1,
    parameter int CNT_W    = 16,
    parameter int SKIP_R0  = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear_i,
    input  logic [NUM_REGS*XLEN-1:0]            regs_i,
    input  logic                                orig_commit_i,
    input  logic                                dup_commit_i,
    input  logic                                sif_commit_i,
    input  logic [NUM_REGS/2-1:0]               pair_mask_i,
    output logic                                check_valid_o,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                pass_o,
    output logic                                fail_o,
    output logic [idx_width(NUM_REGS/2)-1:0]    fail_idx_o,
    output logic [CNT_W-1:0]                    check_cnt_o
);

    localparam int PAIRS = NUM_REGS / 2;
    localparam int BEATS = PAIRS / LANES;
    localparam int IDXW  = idx_width(PAIRS);
    localparam int BEATW = $clog2(BEATS) + 1;
    localparam int LW    = LANES * XLEN;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (!params_ok(NUM_REGS, LANES)) begin : g_bad_params
        $error("qed_consistency_checker: NUM_REGS must be even and LANES must divide NUM_REGS/2");
    end

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         orig_cnt_q, orig_cnt_d, dup_cnt_q, dup_cnt_d;
    logic [CNT_W-1:0]         check_cnt_q, check_cnt_d;
    logic                     sat_q, sat_d, seen_q, seen_d;
    logic                     check_valid_q, check_valid_d, mismatch_q, mismatch_d;
    logic [BEATW-1:0]         beat_q, beat_d;
    logic [IDXW-1:0]          fail_idx_q, fail_idx_d;
    logic [NUM_REGS*XLEN-1:0] snap_q, snap_d;
    logic [PAIRS-1:0]         mask_q, mask_d;
    logic                     capture;
    logic [IDXW-1:0]          base_idx, lane_mis_idx;
    logic [LW-1:0]            orig_lanes, dup_lanes;
    logic [LANES-1:0]         mask_lanes;
    logic                     lane_mismatch;

    always_comb begin
        orig_cnt_d = orig_cnt_q;
        dup_cnt_d  = dup_cnt_q;
        sat_d      = sat_q;
        seen_d     = seen_q | orig_commit_i | dup_commit_i;
        if (orig_commit_i) begin
            if (orig_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                       orig_cnt_d = orig_cnt_q + CNT_W'(1);
        end
        if (dup_commit_i) begin
            if (dup_cnt_q == CNT_MAX) sat_d = 1'b1;
            else                      dup_cnt_d = dup_cnt_q + CNT_W'(1);
        end
        // Computed from next-state counters so the flag tracks the counters without lag.
        check_valid_d = seen_d && !sat_d && (orig_cnt_d == dup_cnt_d);
    end

    always_comb begin
        base_idx   = IDXW'(int'(beat_q) * LANES);
        orig_lanes = LW'(snap_q >> (int'(base_idx) * XLEN));
        dup_lanes  = LW'(snap_q >> ((int'(base_idx) + PAIRS) * XLEN));
        mask_lanes = LANES'(mask_q >> base_idx);
    end

    qed_pair_compare #(
        .XLEN    (XLEN),
        .LANES   (LANES),
        .IDX_W   (IDXW),
        .SKIP_R0 (SKIP_R0)
    ) u_cmp (
        .orig_i         (orig_lanes),
        .dup_i          (dup_lanes),
        .mask_i         (mask_lanes),
        .base_i         (base_idx),
        .any_mismatch_o (lane_mismatch),
        .mis_idx_o      (lane_mis_idx)
    );

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        mismatch_d  = mismatch_q;
        fail_idx_d  = fail_idx_q;
        check_cnt_d = check_cnt_q;
        capture     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sif_commit_i && check_valid_q) begin
                    capture    = 1'b1;
                    beat_d     = '0;
                    mismatch_d = 1'b0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (lane_mismatch) begin
                    fail_idx_d = lane_mis_idx;
                    mismatch_d = 1'b1;
                    state_d    = ST_REPORT;
                end else if (beat_q == BEATW'(BEATS - 1)) begin
                    state_d = ST_REPORT;
                end else begin
                    beat_d = beat_q + BEATW'(1);
                end
            end
            ST_REPORT: begin
                if (check_cnt_q != CNT_MAX) check_cnt_d = check_cnt_q + CNT_W'(1);
                state_d = mismatch_q ? ST_FAIL : ST_IDLE;
            end
            ST_FAIL: ;
            default: state_d = ST_IDLE;
        endcase
        snap_d = capture ? regs_i : snap_q;
        mask_d = capture ? pair_mask_i : mask_q;
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            state_q       <= ST_IDLE;
            orig_cnt_q    <= '0;
            dup_cnt_q     <= '0;
            check_cnt_q   <= '0;
            sat_q         <= 1'b0;
            seen_q        <= 1'b0;
            check_valid_q <= 1'b0;
            mismatch_q    <= 1'b0;
            beat_q        <= '0;
            fail_idx_q    <= '0;
        end else begin
            state_q       <= state_d;
            orig_cnt_q    <= orig_cnt_d;
            dup_cnt_q     <= dup_cnt_d;
            check_cnt_q   <= check_cnt_d;
            sat_q         <= sat_d;
            seen_q        <= seen_d;
            check_valid_q <= check_valid_d;
            mismatch_q    <= mismatch_d;
            beat_q        <= beat_d;
            fail_idx_q    <= fail_idx_d;
        end
    end

    // Snapshot is only meaningful after a capture, so it needs no reset.
    always_ff @(posedge clk) begin
        snap_q <= snap_d;
        mask_q <= mask_d;
    end

    assign check_valid_o = check_valid_q;
    assign busy_o        = (state_q == ST_SCAN) || (state_q == ST_REPORT);
    assign done_o        = (state_q == ST_REPORT);
    assign pass_o        = (state_q == ST_REPORT) && !mismatch_q;
    assign fail_o        = (state_q == ST_FAIL);
    assign fail_idx_o    = fail_idx_q;
    assign check_cnt_o   = check_cnt_q;

endmodule

// File: tb/tb_qed_consistency_checker.sv
// Scoreboard bench: default, LANES=4 and CNT_W=4 builds of the QED consistency checker.
module tb_qed_consistency_checker;

    localparam int XLEN = 32;
    localparam int NR   = 32;
    localparam int NP   = NR / 2;
    localparam int RW   = NR * XLEN;

    typedef struct {
        int         dut;
        logic       pass;
        logic [3:0] idx;
        int         req;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int   n_vec    = 0;
    int   n_mis    = 0;
    int   edge_cnt = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          d_clear = 1'b0, d_oc = 1'b0, d_dc = 1'b0, d_sif = 1'b0;
    logic [RW-1:0] d_regs;
    logic [NP-1:0] d_mask = '0;
    logic          d_cv, d_busy, d_done, d_pass, d_fail;
    logic [3:0]    d_idx;
    logic [15:0]   d_cnt;

    logic          l_clear = 1'b0, l_oc = 1'b0, l_dc = 1'b0, l_sif = 1'b0;
    logic [RW-1:0] l_regs;
    logic [NP-1:0] l_mask = '0;
    logic          l_cv, l_busy, l_done, l_pass, l_fail;
    logic [3:0]    l_idx;
    logic [15:0]   l_cnt;

    logic          c_clear = 1'b0, c_oc = 1'b0, c_dc = 1'b0, c_sif = 1'b0;
    logic [RW-1:0] c_regs;
    logic [NP-1:0] c_mask = '0;
    logic          c_cv, c_busy, c_done, c_pass, c_fail;
    logic [3:0]    c_idx;
    logic [3:0]    c_cnt;

    qed_consistency_checker u_def (
        .clk(clk), .rst(rst), .clear_i(d_clear), .regs_i(d_regs),
        .orig_commit_i(d_oc), .dup_commit_i(d_dc), .sif_commit_i(d_sif), .pair_mask_i(d_mask),
        .check_valid_o(d_cv), .busy_o(d_busy), .done_o(d_done), .pass_o(d_pass),
        .fail_o(d_fail), .fail_idx_o(d_idx), .check_cnt_o(d_cnt)
    );

    qed_consistency_checker #(.LANES(4)) u_l4 (
        .clk(clk), .rst(rst), .clear_i(l_clear), .regs_i(l_regs),
        .orig_commit_i(l_oc), .dup_commit_i(l_dc), .sif_commit_i(l_sif), .pair_mask_i(l_mask),
        .check_valid_o(l_cv), .busy_o(l_busy), .done_o(l_done), .pass_o(l_pass),
        .fail_o(l_fail), .fail_idx_o(l_idx), .check_cnt_o(l_cnt)
    );

    qed_consistency_checker #(.CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .clear_i(c_clear), .regs_i(c_regs),
        .orig_commit_i(c_oc), .dup_commit_i(c_dc), .sif_commit_i(c_sif), .pair_mask_i(c_mask),
        .check_valid_o(c_cv), .busy_o(c_busy), .done_o(c_done), .pass_o(c_pass),
        .fail_o(c_fail), .fail_idx_o(c_idx), .check_cnt_o(c_cnt)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] base_regs();
        logic [RW-1:0] r;
        r = '0;
        for (int k = 0; k < NR; k++)
            r[k*XLEN +: XLEN] = 32'h1000_0000 + 32'(k % NP) * 32'h0000_0101;
        return r;
    endfunction

    // Called just before raising sif_commit_i; the next edge is the sampling edge.
    task automatic expect_done(input int dut, input logic pass, input logic [3:0] idx, input int lat);
        exp_t e;
        e.dut  = dut;
        e.pass = pass;
        e.idx  = idx;
        e.req  = edge_cnt + 1;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic mon(input int dut, input logic done, input logic pass, input logic [3:0] idx);
        int k;
        int lat;
        k = -1;
        if (done !== 1'b1) return;
        n_vec++;
        foreach (sb[i]) if (k < 0 && sb[i].dut == dut) k = i;
        if (k < 0) begin
            n_mis++;
            $display("FAIL done_dut%0d: got unexpected done_o after edge %0d, expected no completion",
                     dut, edge_cnt);
            return;
        end
        lat = edge_cnt - sb[k].req + 1;
        if (pass !== sb[k].pass || lat != sb[k].lat || (!sb[k].pass && idx !== sb[k].idx)) begin
            n_mis++;
            $display("FAIL done_dut%0d: got pass=%0b idx=%0d latency=%0d, expected pass=%0b idx=%0d latency=%0d",
                     dut, pass, idx, lat, sb[k].pass, sb[k].idx, sb[k].lat);
        end
        sb.delete(k);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            mon(0, d_done, d_pass, d_idx);
            mon(1, l_done, l_pass, l_idx);
            mon(2, c_done, c_pass, c_idx);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        d_regs = base_regs();
        l_regs = base_regs();
        c_regs = base_regs();
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_check_valid", d_cv, 0);
        chk("rst_busy", d_busy, 0);
        chk("rst_done", d_done, 0);
        chk("rst_pass", d_pass, 0);
        chk("rst_fail", d_fail, 0);
        chk("rst_fail_idx", d_idx, 0);
        chk("rst_check_cnt", d_cnt, 0);

        // default build: 3 orig + 3 dup, full pass
        d_oc = 1'b1; d_dc = 1'b1; tick(3); d_oc = 1'b0; d_dc = 1'b0;
        chk("cv_after_3_3", d_cv, 1);
        expect_done(0, 1'b1, 4'd0, 17);
        d_sif = 1'b1; tick(1); d_sif = 1'b0;
        chk("busy_in_scan", d_busy, 1);
        tick(20);
        chk("cnt_after_pass", d_cnt, 1);
        chk("fail_after_pass", d_fail, 0);
        chk("busy_after_pass", d_busy, 0);

        // masked pair 7, r0 differs (skipped), live regs_i change mid-scan
        d_regs[0 +: XLEN]      = 32'h0000_0001;
        d_regs[7*XLEN +: XLEN] = 32'h0BAD_0007;
        d_mask[7] = 1'b1;
        expect_done(0, 1'b1, 4'd0, 17);
        d_sif = 1'b1; tick(1); d_sif = 1'b0;
        d_mask = '0;
        d_regs[3*XLEN +: XLEN] = 32'hFFFF_0003;
        tick(20);
        chk("cnt_after_mask", d_cnt, 2);
        d_regs = base_regs();

        // unbalanced counts (5 orig vs 4 dup): request ignored
        d_oc = 1'b1; d_dc = 1'b1; tick(1); d_dc = 1'b0; tick(1); d_oc = 1'b0;
        chk("cv_unequal", d_cv, 0);
        d_sif = 1'b1; tick(1); d_sif = 1'b0;
        chk("busy_unequal", d_busy, 0);
        tick(20);
        d_dc = 1'b1; tick(1); d_dc = 1'b0;
        chk("cv_rebalanced", d_cv, 1);

        // mismatch at pair 5
        d_regs[5*XLEN +: XLEN]  = 32'hDEAD_BEEF;
        d_regs[21*XLEN +: XLEN] = 32'hDEAD_BEEE;
        expect_done(0, 1'b0, 4'd5, 7);
        d_sif = 1'b1; tick(1); d_sif = 1'b0;
        tick(10);
        chk("fail_sticky", d_fail, 1);
        chk("fail_idx_5", d_idx, 5);
        chk("cnt_after_fail", d_cnt, 3);
        d_sif = 1'b1; tick(1); d_sif = 1'b0;
        chk("busy_in_fail", d_busy, 0);
        tick(20);
        chk("cnt_fail_ignored", d_cnt, 3);
        chk("fail_still_set", d_fail, 1);
        d_clear = 1'b1; tick(1); d_clear = 1'b0;
        chk("clr_fail", d_fail, 0);
        chk("clr_fail_idx", d_idx, 0);
        chk("clr_cnt", d_cnt, 0);
        chk("clr_cv", d_cv, 0);

        // LANES=4 build: full pass then mismatches at pairs 9 and 10
        l_oc = 1'b1; l_dc = 1'b1; tick(1); l_oc = 1'b0; l_dc = 1'b0;
        chk("l4_cv", l_cv, 1);
        expect_done(1, 1'b1, 4'd0, 5);
        l_sif = 1'b1; tick(1); l_sif = 1'b0;
        tick(8);
        chk("l4_cnt", l_cnt, 1);
        l_regs[9*XLEN +: XLEN]  = 32'h0000_0099;
        l_regs[10*XLEN +: XLEN] = 32'h0000_00AA;
        expect_done(1, 1'b0, 4'd9, 4);
        l_sif = 1'b1; tick(1); l_sif = 1'b0;
        tick(8);
        chk("l4_fail", l_fail, 1);
        chk("l4_fail_idx", l_idx, 9);

        // CNT_W=4 build: clear mid-scan, then saturation
        c_oc = 1'b1; c_dc = 1'b1; tick(1); c_oc = 1'b0; c_dc = 1'b0;
        c_sif = 1'b1; tick(1); c_sif = 1'b0;
        tick(1);
        chk("c4_busy_mid", c_busy, 1);
        c_clear = 1'b1; tick(1); c_clear = 1'b0;
        chk("c4_clr_busy", c_busy, 0);
        chk("c4_clr_done", c_done, 0);
        chk("c4_clr_cv", c_cv, 0);
        chk("c4_clr_cnt", c_cnt, 0);
        tick(20);
        c_oc = 1'b1; c_dc = 1'b1; tick(16); c_oc = 1'b0; c_dc = 1'b0;
        chk("c4_cv_sat", c_cv, 0);
        c_sif = 1'b1; tick(1); c_sif = 1'b0;
        chk("c4_busy_sat", c_busy, 0);
        tick(20);

        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
